// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with per-frame snapshot, dead-time, blank and blink.
// Optional leading-zero blanking is enabled by defining SEVENSEG_LZ_BLANK_EN.
module sevenseg_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int DEAD_CYCLES  = 2,
    parameter int BLINK_FRAMES = 64,
    parameter int COMMON_ANODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_tick
);

    localparam int S_W = $clog2(SCAN_DIV);
    localparam int D_W = $clog2(DIGITS);
    localparam int F_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [S_W-1:0] S_LAST = S_W'(SCAN_DIV - 1);
    localparam logic [S_W-1:0] S_DEAD = S_W'(DEAD_CYCLES);
    localparam logic [D_W-1:0] D_LAST = D_W'(DIGITS - 1);
    localparam logic [F_W-1:0] F_LAST = F_W'(BLINK_FRAMES - 1);
    localparam logic           POL    = (COMMON_ANODE != 0) ? 1'b1 : 1'b0;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [S_W-1:0]      r_s;
    logic [D_W-1:0]      r_d;
    logic [F_W-1:0]      r_fcnt;
    logic                r_blink_phase;
    logic [4*DIGITS-1:0] r_dig_sh;
    logic [DIGITS-1:0]   r_dp_sh;
    logic [DIGITS-1:0]   r_blank_sh;
    logic [DIGITS-1:0]   r_blink_sh;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_dig;
    logic                r_tick;

    logic                w_slot_end;
    logic                w_frame_end;
    logic                w_snap;
    logic [DIGITS-1:0]   w_blank_load;
    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_onehot;
    logic [6:0]          w_seg_act;
    logic                w_dp_act;
    logic [DIGITS-1:0]   w_dig_act;

    assign w_slot_end  = (r_s == S_LAST);
    assign w_frame_end = w_slot_end && (r_d == D_LAST);
    assign w_snap      = ena && (r_s == '0) && (r_d == '0);
    assign w_onehot    = {{(DIGITS-1){1'b0}}, 1'b1} << r_d;

`ifdef SEVENSEG_LZ_BLANK_EN
    logic w_lz_lead;

    // Leading-zero mask: walk down from the top digit while nibble and dp are both zero; digit 0 is exempt.
    always_comb begin
        w_blank_load = blank_mask;
        w_lz_lead    = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (w_lz_lead && (digits_in[4*k +: 4] == 4'h0) && !dp_in[k]) begin
                w_blank_load[k] = 1'b1;
            end else begin
                w_lz_lead = 1'b0;
            end
        end
    end
`else
    assign w_blank_load = blank_mask;
`endif

    // Select the shadow nibble for the digit currently being scanned.
    always_comb begin
        w_nib = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            w_nib = (r_d == D_W'(k)) ? r_dig_sh[4*k +: 4] : w_nib;
        end
    end

    // Pre-polarity pin values for the current scan state.
    always_comb begin
        w_seg_act = 7'h00;
        w_dp_act  = 1'b0;
        w_dig_act = '0;
        if ((r_s >= S_DEAD) && !r_blank_sh[r_d]) begin
            w_dig_act = w_onehot;
            if (r_blink_sh[r_d] && r_blink_phase) begin
                w_seg_act = 7'h00;
                w_dp_act  = 1'b0;
            end else begin
                w_seg_act = hex7(w_nib);
                w_dp_act  = r_dp_sh[r_d];
            end
        end else begin
            w_seg_act = 7'h00;
            w_dp_act  = 1'b0;
            w_dig_act = '0;
        end
    end

    // Slot/digit scan counters and blink frame counter; all freeze while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s           <= '0;
            r_d           <= '0;
            r_fcnt        <= '0;
            r_blink_phase <= 1'b0;
        end else if (ena) begin
            if (w_slot_end) begin
                r_s <= '0;
                r_d <= (r_d == D_LAST) ? '0 : r_d + D_W'(1);
            end else begin
                r_s <= r_s + S_W'(1);
            end
            if (w_frame_end) begin
                if (r_fcnt == F_LAST) begin
                    r_fcnt        <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_fcnt <= r_fcnt + F_W'(1);
                end
            end
        end
    end

    // Frame-start snapshot so a frame never shows a half-updated value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig_sh   <= '0;
            r_dp_sh    <= '0;
            r_blank_sh <= '0;
            r_blink_sh <= '0;
        end else if (w_snap) begin
            r_dig_sh   <= digits_in;
            r_dp_sh    <= dp_in;
            r_blank_sh <= w_blank_load;
            r_blink_sh <= blink_mask;
        end
    end

    // Registered pins; polarity is applied only here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg  <= {7{POL}};
            r_dp   <= POL;
            r_dig  <= {DIGITS{POL}};
            r_tick <= 1'b0;
        end else if (ena) begin
            r_seg  <= w_seg_act ^ {7{POL}};
            r_dp   <= w_dp_act ^ POL;
            r_dig  <= w_dig_act ^ {DIGITS{POL}};
            r_tick <= w_frame_end;
        end else begin
            r_seg  <= {7{POL}};
            r_dp   <= POL;
            r_dig  <= {DIGITS{POL}};
            r_tick <= 1'b0;
        end
    end

    assign seg_out    = r_seg;
    assign dp_out     = r_dp;
    assign dig_sel    = r_dig;
    assign frame_tick = r_tick;

endmodule
